// File: rtl/meas_batch_accum_if.sv
// Handshake and data bundle between the batch accumulator and its producer/consumer.
interface meas_batch_accum_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LOG2_N = 4
);
  logic                     start_i;
  logic [DATA_W-1:0]        sample_i;
  logic                     sample_valid_i;
  logic                     busy_o;
  logic                     done_valid_o;
  logic                     done_ready_i;
  logic [DATA_W+LOG2_N-1:0] sum_o;
  logic [DATA_W-1:0]        avg_o;
  logic [DATA_W-1:0]        min_o;
  logic [DATA_W-1:0]        max_o;
  logic                     overrun_o;

  // Accumulator side.
  modport slave (
    input  start_i, sample_i, sample_valid_i, done_ready_i,
    output busy_o, done_valid_o, sum_o, avg_o, min_o, max_o, overrun_o
  );

  // Producer/consumer side.
  modport master (
    output start_i, sample_i, sample_valid_i, done_ready_i,
    input  busy_o, done_valid_o, sum_o, avg_o, min_o, max_o, overrun_o
  );
endinterface

// File: rtl/meas_batch_accum.sv
// Reduces a batch of 2^LOG2_N unsigned samples into sum/avg/min/max and
// presents the result through a valid/ready handshake.
module meas_batch_accum #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LOG2_N = 4
) (
  input logic                 clk_i,
  input logic                 rst_i,
  meas_batch_accum_if.slave   bus
);
  localparam int unsigned SumW = DATA_W + LOG2_N;
  localparam int unsigned N    = 1 << LOG2_N;
  localparam logic [LOG2_N:0] CntLast = (LOG2_N + 1)'(N - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e              state_q, state_d;
  logic [LOG2_N:0]     cnt_q, cnt_d;
  logic [SumW-1:0]     sum_q, sum_d;
  logic [DATA_W-1:0]   min_q, min_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state: batch clear on start, reduction in ACCUM, handshake and overrun in HOLD.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    min_d     = min_q;
    max_d     = max_q;
    overrun_d = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          state_d   = StAccum;
          cnt_d     = '0;
          sum_d     = '0;
          min_d     = '1;
          max_d     = '0;
          overrun_d = 1'b0;
        end
      end
      StAccum: begin
        if (bus.start_i) begin
          // Restart wins over a coincident sample.
          cnt_d     = '0;
          sum_d     = '0;
          min_d     = '1;
          max_d     = '0;
          overrun_d = 1'b0;
        end else if (bus.sample_valid_i) begin
          cnt_d = cnt_q + 1'b1;
          sum_d = sum_q + {{LOG2_N{1'b0}}, bus.sample_i};
          if (bus.sample_i < min_q) min_d = bus.sample_i;
          if (bus.sample_i > max_q) max_d = bus.sample_i;
          if (cnt_q == CntLast) state_d = StHold;
        end
      end
      StHold: begin
        // No back-pressure upstream: a sample here is lost, so flag it.
        if (bus.sample_valid_i) overrun_d = 1'b1;
        if (bus.done_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StAccum);
    done_d = (state_d == StHold);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sum_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      min_q     <= min_d;
      max_q     <= max_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.done_valid_o = done_q;
  assign bus.sum_o        = sum_q;
  assign bus.avg_o        = sum_q[SumW-1:LOG2_N];
  assign bus.min_o        = min_q;
  assign bus.max_o        = max_q;
  assign bus.overrun_o    = overrun_q;
endmodule

// File: doc/meas_batch_accum.md
Name: meas_batch_accum

Overview:
- Sits directly downstream of the measure unit's two-cycle 32-bit adder. Consumes its valid-qualified 32-bit results.
- Reduces a batch of 2^LOG2_N results into sum, average, minimum and maximum.
- Presents the batch result to the control/register side through a valid/ready handshake.
- Samples arriving while a result is still pending are dropped and flagged.

Parameters:
- DATA_W, 32, width of incoming results (unsigned).
- LOG2_N, 4, log2 of batch length; N = 2^LOG2_N samples per batch (LOG2_N >= 1).

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  arm/clear a new batch (single-cycle pulse).
- sample_i  in  DATA_W  adder result (res_o of upstream).
- sample_valid_i  in  1  sample_i valid this cycle (valid_o of upstream); no back-pressure to upstream.
- busy_o  out  1  batch in progress.
- done_valid_o  out  1  batch result valid.
- done_ready_i  in  1  consumer accepts result.
- sum_o  out  DATA_W+LOG2_N  unsigned sum of batch.
- avg_o  out  DATA_W  sum_o >> LOG2_N.
- min_o  out  DATA_W  smallest sample of batch.
- max_o  out  DATA_W  largest sample of batch.
- overrun_o  out  1  sticky: sample dropped while result pending.

Behaviour:
- Reset (rst_i=1 at posedge, any state, including mid-batch):
  - state -> IDLE; sample counter cleared.
  - busy_o, done_valid_o, overrun_o = 0; sum_o, avg_o, min_o, max_o = 0.
- FSM states:
  - IDLE:
    - sample_valid_i ignored; overrun_o unaffected.
    - start_i=1 -> ACCUM: sum=0, min=all-ones, max=0, cnt=0, overrun_o=0.
    - A sample coincident with start_i is not counted.
  - ACCUM (busy_o=1):
    - Each cycle with sample_valid_i=1: sum += zero-extended sample; min = min(min, sample); max = max(max, sample); cnt++.
    - Cycles with sample_valid_i=0 change nothing; gaps are allowed.
    - When the N-th sample is accepted -> HOLD. done_valid_o=1 and busy_o=0 on the next cycle, with all result outputs final.
    - Latency: 1 cycle from N-th accepted sample to done_valid_o.
    - start_i=1 in ACCUM restarts the batch: same clear as from IDLE; a coincident sample is discarded; start wins.
  - HOLD (done_valid_o=1):
    - sum_o, avg_o, min_o, max_o held stable until handshake.
    - done_valid_o & done_ready_i at posedge -> IDLE; done_valid_o=0 next cycle; result outputs retain their values.
    - sample_valid_i=1 in HOLD: sample dropped, overrun_o set to 1 (sticky until next accepted start_i or reset).
    - start_i in HOLD ignored.
- Handshake rules:
  - done_valid_o never deasserts without done_ready_i, except on reset.
  - done_ready_i while done_valid_o=0 has no effect.
- Arithmetic:
  - Unsigned throughout.
  - Sum width DATA_W+LOG2_N, so the sum never overflows for N samples.
  - avg_o = truncating shift (floor), no rounding.
  - min/max use unsigned compare.
  - Ties leave the value unchanged.
- Counter width is LOG2_N+1 bits; it terminates at N exactly.
- Between batches, min_o/max_o/sum_o/avg_o are meaningful only while done_valid_o=1.
- Internal all-ones min seed is visible on min_o during ACCUM; consumers must not sample it then.

Test Plan:
1. Reset, start_i pulse, then 16 back-to-back samples 1..16 -> done_valid_o=1 exactly 1 cycle after 16th; sum_o=136, avg_o=8, min_o=1, max_o=16, overrun_o=0, busy_o=0.
2. Full-scale: 16 samples of 0xFFFFFFFF with random valid gaps -> sum_o=0xF_FFFF_FFF0, avg_o=0xFFFFFFFF, min_o=max_o=0xFFFFFFFF.
3. Back-pressure: result ready, done_ready_i low 5 cycles with 3 samples presented -> outputs stable, overrun_o=1; ready high -> IDLE next cycle; next start_i clears overrun_o to 0.
4. Restart: start, 5 samples of 100, then start_i and sample_valid_i (value 7) same cycle -> batch cleared, 7 not counted; 16 more samples of 2 -> sum_o=32, min_o=max_o=2.
5. Reset mid-ACCUM after 9 samples -> next cycle all outputs 0, busy_o=0; samples without start_i are ignored; a fresh batch then completes normally.
6. Floor average: 16 samples (15×0, 1×15) -> sum_o=15, avg_o=0, min_o=0, max_o=15.
